mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-serial memory controller between instruction fetch (IF) and the load/store buffer (LSB).
//  Holds one request on the downstream port at a time and routes each completion back to the requester that issued it.
//  Applies LSB-first priority, with an age counter so that IF cannot starve.
//  Discards a completion in flight when a rollback cancels its request.
// PARAMETERS
//  STARVE_LIM  8    IF-waiting cycles after which IF wins the next arbitration (1..255)
//  IF_LEN      64   byte count sent on mc_len for an IF line fill
// PORTS
//  clk          in   1    clock, all state on posedge
//  rst          in   1    asynchronous, active-low reset
//  rdy          in   1    global enable; when low, all state holds and done outputs are forced 0
//  rollback     in   1    pipeline flush
//  if_req       in   1    IF request, level; held until if_done
//  if_addr      in   32   IF line address
//  if_done      out  1    1-cycle pulse: IF data valid on mc_rdata path
//  lsb_req      in   1    LSB request, level; held until lsb_done
//  lsb_wr       in   1    1=store, 0=load
//  lsb_addr     in   32   byte address
//  lsb_len      in   3    bytes (1,2,4)
//  lsb_wdata    in   32   store data
//  lsb_done     out  1    1-cycle pulse: load data valid / store committed
//  mc_en        out  1    downstream request, held until mc_done
//  mc_wr        out  1    downstream write
//  mc_addr      out  32   downstream address
//  mc_len       out  7    downstream byte count
//  mc_wdata     out  32   downstream store data
//  mc_done      in   1    downstream completion pulse, exactly one per issued request
// BEHAVIOUR
//  Reset: state=IDLE, starve=0.
//   All outputs are 0: mc_en, mc_wr, mc_addr, mc_len, mc_wdata, if_done, lsb_done.
//  FSM states: IDLE, GNT_IF, GNT_LSB, DRAIN, GAP.
//  IDLE:
//   - Arbitration runs only when rollback=0.
//   - If lsb_req=1 and (if_req=0 or starve<STARVE_LIM): latch the lsb_* fields into the mc_* registers, mc_en<=1 -> GNT_LSB.
//   - Else if if_req=1: mc_addr<=if_addr, mc_len<=IF_LEN, mc_wr<=0, mc_en<=1 -> GNT_IF.
//   - Grant takes effect one cycle after the request is sampled. Downstream fields stay stable while mc_en=1.
//  GNT_x:
//   - On mc_done: pulse x_done for exactly 1 cycle, mc_en<=0 -> GAP.
//   - x_done coincides with the cycle after mc_done.
//  GAP:
//   - Unconditional single cycle -> IDLE.
//   - Lets the requester drop its req, so the completed request is not re-granted.
//  Starvation counter:
//   - starve increments (saturating at 255) each cycle IF is pending and not granted.
//   - Clears when IF is granted or when if_req=0.
//  Rollback:
//   - In GNT_IF, or in GNT_LSB with mc_wr=0: -> DRAIN, keep mc_en high until mc_done, then -> GAP.
//     No done pulse is issued for the cancelled request.
//   - In GNT_LSB with mc_wr=1: unaffected. Stores are committed and must complete, and lsb_done still pulses.
//   - In IDLE: blocks arbitration that cycle.
//  Simultaneous rollback and mc_done in GNT_IF/load: the completion is discarded (no done pulse) -> GAP.
//  rdy=0: state and counters freeze; mc_* held; done outputs 0. A pending done pulse is reissued when rdy returns.
//  Reset mid-transfer: immediate return to IDLE, and mc_en drops asynchronously.
//   The downstream controller is reset by the same signal.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined:
//   - Adds outputs perf_if_cnt[31:0], perf_lsb_cnt[31:0], perf_stall_cnt[31:0].
//   - perf_if_cnt and perf_lsb_cnt count granted requests; a drained grant still counts.
//   - perf_stall_cnt counts cycles with a request pending and the FSM not in IDLE.
//   - All three wrap at 2^32 and reset to 0.
//  MEM_ARB_PERF_EN undefined: these ports and counters are absent. Arbitration behaviour is identical.
// TESTING
//  1. if_req, if_addr=0x1000 alone -> mc_en=1, mc_addr=0x1000, mc_len=64 next cycle; mc_done -> if_done pulse of 1 cycle.
//  2. if_req and lsb_req (load, addr 0x20, len 4) in the same cycle -> LSB granted first. After GAP, IF is granted with no req drop needed.
//  3. STARVE_LIM=3, IF held while LSB issues back-to-back 1-cycle-done loads -> IF granted on the grant following starve=3.
//  4. Rollback during an IF grant -> mc_en held until mc_done, no if_done, then IDLE; a new lsb_req is granted after GAP.
//  5. Rollback during a store (addr 0x30000, data 0xAB) -> store completes and lsb_done pulses once.
//  6. rst low asserted mid-GNT_LSB -> mc_en=0 asynchronously. Without MEM_ARB_PERF_EN the build has no perf ports; with it, perf_lsb_cnt=1 after scenario 2.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter that shares one byte-serial memory controller between instruction fetch and the load/store buffer.
// Define MEM_ARB_PERF_EN to add the grant and stall performance counters.
module mem_arbiter #(
    parameter int STARVE_LIM = 8,
    parameter int IF_LEN     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    input  logic        lsb_req,
    input  logic        lsb_wr,
    input  logic [31:0] lsb_addr,
    input  logic [2:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic        mc_en,
    output logic        mc_wr,
    output logic [31:0] mc_addr,
    output logic [6:0]  mc_len,
    output logic [31:0] mc_wdata,
    input  logic        mc_done
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_if_cnt,
    output logic [31:0] perf_lsb_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        GNT_IF,
        GNT_LSB,
        DRAIN,
        GAP
    } state_t;

    localparam logic [7:0] LIM      = 8'(STARVE_LIM);
    localparam logic [6:0] IF_LEN_W = 7'(IF_LEN);

    state_t      state, state_nxt;
    logic [7:0]  starve, starve_nxt;
    logic        mc_en_nxt, mc_wr_nxt;
    logic [31:0] mc_addr_nxt, mc_wdata_nxt;
    logic [6:0]  mc_len_nxt;
    logic        if_done_q, if_done_nxt;
    logic        lsb_done_q, lsb_done_nxt;
    logic        grant_if, grant_lsb;
    logic        cancel;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A load or fetch can be abandoned on rollback; a store is already committed.
    assign cancel = rollback && ((state == GNT_IF) || ((state == GNT_LSB) && !mc_wr));

    always_comb begin
        state_nxt    = state;
        mc_en_nxt    = mc_en;
        mc_wr_nxt    = mc_wr;
        mc_addr_nxt  = mc_addr;
        mc_len_nxt   = mc_len;
        mc_wdata_nxt = mc_wdata;
        if_done_nxt  = 1'b0;
        lsb_done_nxt = 1'b0;
        grant_if     = 1'b0;
        grant_lsb    = 1'b0;
        case (state)
            IDLE: begin
                if (!rollback) begin
                    if (lsb_req && (!if_req || (starve < LIM))) begin
                        grant_lsb    = 1'b1;
                        mc_en_nxt    = 1'b1;
                        mc_wr_nxt    = lsb_wr;
                        mc_addr_nxt  = lsb_addr;
                        mc_len_nxt   = {4'd0, lsb_len};
                        mc_wdata_nxt = lsb_wdata;
                        state_nxt    = GNT_LSB;
                    end else if (if_req) begin
                        grant_if     = 1'b1;
                        mc_en_nxt    = 1'b1;
                        mc_wr_nxt    = 1'b0;
                        mc_addr_nxt  = if_addr;
                        mc_len_nxt   = IF_LEN_W;
                        mc_wdata_nxt = '0;
                        state_nxt    = GNT_IF;
                    end
                end
            end
            GNT_IF, GNT_LSB: begin
                if (mc_done) begin
                    mc_en_nxt = 1'b0;
                    state_nxt = GAP;
                    if (!cancel) begin
                        if_done_nxt  = (state == GNT_IF);
                        lsb_done_nxt = (state == GNT_LSB);
                    end
                end else if (cancel) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (mc_done) begin
                    mc_en_nxt = 1'b0;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        starve_nxt = starve;
        if (!if_req || grant_if) begin
            starve_nxt = 8'd0;
        end else if (state != GNT_IF) begin
            starve_nxt = sat_inc(starve);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve     <= 8'd0;
            mc_en      <= 1'b0;
            mc_wr      <= 1'b0;
            mc_addr    <= '0;
            mc_len     <= '0;
            mc_wdata   <= '0;
            if_done_q  <= 1'b0;
            lsb_done_q <= 1'b0;
        end else if (rdy) begin
            state      <= state_nxt;
            starve     <= starve_nxt;
            mc_en      <= mc_en_nxt;
            mc_wr      <= mc_wr_nxt;
            mc_addr    <= mc_addr_nxt;
            mc_len     <= mc_len_nxt;
            mc_wdata   <= mc_wdata_nxt;
            if_done_q  <= if_done_nxt;
            lsb_done_q <= lsb_done_nxt;
        end
    end

    // Done pulses are held in their registers while stalled and reappear once rdy returns.
    assign if_done  = if_done_q & rdy;
    assign lsb_done = lsb_done_q & rdy;

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_cnt    <= 32'd0;
            perf_lsb_cnt   <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else if (rdy) begin
            if (grant_if) begin
                perf_if_cnt <= perf_if_cnt + 32'd1;
            end
            if (grant_lsb) begin
                perf_lsb_cnt <= perf_lsb_cnt + 32'd1;
            end
            if ((if_req || lsb_req) && (state != IDLE)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_arbiter;
    localparam int LIM = 3;
    localparam int IFL = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        rollback = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_done;
    logic        lsb_req = 1'b0;
    logic        lsb_wr = 1'b0;
    logic [31:0] lsb_addr = '0;
    logic [2:0]  lsb_len = '0;
    logic [31:0] lsb_wdata = '0;
    logic        lsb_done;
    logic        mc_en, mc_wr;
    logic [31:0] mc_addr, mc_wdata;
    logic [6:0]  mc_len;
    logic        mc_done = 1'b0;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_cnt, perf_lsb_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIM(LIM), .IF_LEN(IFL)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
        .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done),
        .mc_en(mc_en), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_len(mc_len),
        .mc_wdata(mc_wdata), .mc_done(mc_done)
`ifdef MEM_ARB_PERF_EN
        , .perf_if_cnt(perf_if_cnt), .perf_lsb_cnt(perf_lsb_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rdy = 1'b1;
        step();
        step();
        checks++; if ({mc_en, mc_wr, mc_len, if_done, lsb_done} !== 11'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", {mc_en, mc_wr, mc_len, if_done, lsb_done}); end
        checks++; if ({mc_addr, mc_wdata} !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {mc_addr, mc_wdata}); end
        rst = 1'b1;
        step();
        checks++; if (mc_en !== 1'b0) begin failures++; $display("FAIL reset_idle mc_en got=%0b exp=0", mc_en); end
    endtask

    task automatic test_lsb_priority();
        if_req = 1'b1; if_addr = 32'h2000;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h20; lsb_len = 3'd4;
        step();
        checks++; if ({mc_en, mc_wr, mc_addr, mc_len} !== {1'b1, 1'b0, 32'h20, 7'd4}) begin failures++; $display("FAIL prio_lsb_grant got=%0b/%0b/%h/%0d exp=1/0/20/4", mc_en, mc_wr, mc_addr, mc_len); end
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        checks++; if ({lsb_done, if_done, mc_en} !== 3'b100) begin failures++; $display("FAIL prio_lsb_done got=%b exp=100", {lsb_done, if_done, mc_en}); end
        lsb_req = 1'b0;
        step();
        checks++; if ({lsb_done, mc_en} !== 2'b00) begin failures++; $display("FAIL prio_gap got=%b exp=00", {lsb_done, mc_en}); end
        step();
        checks++; if ({mc_en, mc_addr, mc_len} !== {1'b1, 32'h2000, 7'd64}) begin failures++; $display("FAIL prio_if_grant got=%0b/%h/%0d exp=1/2000/64", mc_en, mc_addr, mc_len); end
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        checks++; if (if_done !== 1'b1) begin failures++; $display("FAIL prio_if_done got=%0b exp=1", if_done); end
        if_req = 1'b0;
        step();
`ifdef MEM_ARB_PERF_EN
        checks++; if (perf_lsb_cnt !== 32'd1) begin failures++; $display("FAIL perf_lsb got=%0d exp=1", perf_lsb_cnt); end
        checks++; if (perf_if_cnt !== 32'd1) begin failures++; $display("FAIL perf_if got=%0d exp=1", perf_if_cnt); end
`endif
    endtask

    task automatic test_if_alone();
        if_req = 1'b1; if_addr = 32'h1000;
        step();
        checks++; if ({mc_en, mc_wr, mc_addr, mc_len} !== {1'b1, 1'b0, 32'h1000, 7'd64}) begin failures++; $display("FAIL if_grant got=%0b/%0b/%h/%0d exp=1/0/1000/64", mc_en, mc_wr, mc_addr, mc_len); end
        step();
        checks++; if ({mc_en, if_done} !== 2'b10) begin failures++; $display("FAIL if_wait got=%b exp=10", {mc_en, if_done}); end
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        checks++; if ({if_done, mc_en} !== 2'b10) begin failures++; $display("FAIL if_done_pulse got=%b exp=10", {if_done, mc_en}); end
        if_req = 1'b0;
        step();
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL if_done_width got=%0b exp=0", if_done); end
    endtask

    task automatic test_starvation();
        if_req = 1'b1; if_addr = 32'h3000;
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h40; lsb_len = 3'd2;
        step();
        checks++; if (mc_addr !== 32'h40) begin failures++; $display("FAIL starve_first got=%h exp=40", mc_addr); end
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        checks++; if (lsb_done !== 1'b1) begin failures++; $display("FAIL starve_lsb_done got=%0b exp=1", lsb_done); end
        step();
        step();
        checks++; if ({mc_en, mc_addr, mc_len} !== {1'b1, 32'h3000, 7'd64}) begin failures++; $display("FAIL starve_if_wins got=%0b/%h/%0d exp=1/3000/64", mc_en, mc_addr, mc_len); end
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        checks++; if ({if_done, lsb_done} !== 2'b10) begin failures++; $display("FAIL starve_if_done got=%b exp=10", {if_done, lsb_done}); end
        if_req = 1'b0;
        step();
        step();
        checks++; if ({mc_en, mc_addr} !== {1'b1, 32'h40}) begin failures++; $display("FAIL starve_lsb_again got=%0b/%h exp=1/40", mc_en, mc_addr); end
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        lsb_req = 1'b0;
        step();
    endtask

    task automatic test_rollback_if();
        if_req = 1'b1; if_addr = 32'h5000;
        step();
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        if_req = 1'b0;
        checks++; if ({mc_en, mc_addr, if_done} !== {1'b1, 32'h5000, 1'b0}) begin failures++; $display("FAIL rb_if_hold got=%0b/%h/%0b exp=1/5000/0", mc_en, mc_addr, if_done); end
        step();
        checks++; if ({mc_en, if_done} !== 2'b10) begin failures++; $display("FAIL rb_if_drain got=%b exp=10", {mc_en, if_done}); end
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h60; lsb_len = 3'd1;
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        checks++; if ({mc_en, if_done, lsb_done} !== 3'b000) begin failures++; $display("FAIL rb_if_nodone got=%b exp=000", {mc_en, if_done, lsb_done}); end
        step();
        checks++; if ({mc_en, if_done} !== 2'b00) begin failures++; $display("FAIL rb_if_idle got=%b exp=00", {mc_en, if_done}); end
        step();
        checks++; if ({mc_en, mc_addr, mc_len} !== {1'b1, 32'h60, 7'd1}) begin failures++; $display("FAIL rb_next_lsb got=%0b/%h/%0d exp=1/60/1", mc_en, mc_addr, mc_len); end
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        checks++; if (lsb_done !== 1'b1) begin failures++; $display("FAIL rb_next_lsb_done got=%0b exp=1", lsb_done); end
        lsb_req = 1'b0;
        step();
    endtask

    task automatic test_rollback_store();
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_len = 3'd1; lsb_wdata = 32'hAB;
        step();
        checks++; if ({mc_en, mc_wr, mc_addr, mc_wdata} !== {1'b1, 1'b1, 32'h30000, 32'hAB}) begin failures++; $display("FAIL st_grant got=%0b/%0b/%h/%h exp=1/1/30000/ab", mc_en, mc_wr, mc_addr, mc_wdata); end
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        checks++; if (mc_en !== 1'b1) begin failures++; $display("FAIL st_survives got=%0b exp=1", mc_en); end
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        checks++; if (lsb_done !== 1'b1) begin failures++; $display("FAIL st_done got=%0b exp=1", lsb_done); end
        lsb_req = 1'b0;
        step();
        checks++; if (lsb_done !== 1'b0) begin failures++; $display("FAIL st_done_once got=%0b exp=0", lsb_done); end
    endtask

    task automatic test_rdy_hold();
        if_req = 1'b1; if_addr = 32'h8000;
        step();
        rdy = 1'b0;
        step();
        step();
        checks++; if ({mc_en, mc_addr} !== {1'b1, 32'h8000}) begin failures++; $display("FAIL rdy_hold got=%0b/%h exp=1/8000", mc_en, mc_addr); end
        rdy = 1'b1;
        mc_done = 1'b1;
        step();
        mc_done = 1'b0;
        checks++; if (if_done !== 1'b1) begin failures++; $display("FAIL rdy_done got=%0b exp=1", if_done); end
        rdy = 1'b0;
        #1;
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL rdy_mask got=%0b exp=0", if_done); end
        step();
        checks++; if ({if_done, mc_en} !== 2'b00) begin failures++; $display("FAIL rdy_frozen got=%b exp=00", {if_done, mc_en}); end
        rdy = 1'b1;
        #1;
        checks++; if (if_done !== 1'b1) begin failures++; $display("FAIL rdy_reissue got=%0b exp=1", if_done); end
        if_req = 1'b0;
        step();
        checks++; if (if_done !== 1'b0) begin failures++; $display("FAIL rdy_after got=%0b exp=0", if_done); end
    endtask

    task automatic test_async_reset();
        lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h70; lsb_len = 3'd4;
        step();
        checks++; if (mc_en !== 1'b1) begin failures++; $display("FAIL ar_grant got=%0b exp=1", mc_en); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({mc_en, mc_addr} !== {1'b0, 32'h0}) begin failures++; $display("FAIL ar_async got=%0b/%h exp=0/0", mc_en, mc_addr); end
        lsb_req = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++; if (mc_en !== 1'b0) begin failures++; $display("FAIL ar_idle got=%0b exp=0", mc_en); end
    endtask

    task automatic test_random();
        int          m_phase, m_owner, m_wait, lat;
        bit          m_cancel, m_wr, m_ifd, m_lsbd, ifd_n, lsbd_n, gi, served, done_issued;
        logic [31:0] m_addr, m_wdata;
        logic [6:0]  m_len;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
        m_phase = 0; m_owner = 0; m_wait = 0; lat = 0;
        m_cancel = 0; m_wr = 0; m_ifd = 0; m_lsbd = 0; done_issued = 0;
        m_addr = '0; m_wdata = '0; m_len = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            checks++; if (if_done !== (m_ifd & rdy)) begin failures++; $display("FAIL rnd_if_done cyc=%0d got=%0b exp=%0b", cyc, if_done, m_ifd & rdy); end
            checks++; if (lsb_done !== (m_lsbd & rdy)) begin failures++; $display("FAIL rnd_lsb_done cyc=%0d got=%0b exp=%0b", cyc, lsb_done, m_lsbd & rdy); end
            checks++; if (mc_en !== (m_phase == 1)) begin failures++; $display("FAIL rnd_mc_en cyc=%0d got=%0b exp=%0b", cyc, mc_en, m_phase == 1); end
            if (m_phase == 1) begin
                checks++; if ({mc_wr, mc_addr, mc_len} !== {m_wr, m_addr, m_len}) begin failures++; $display("FAIL rnd_fields cyc=%0d got=%0b/%h/%0d exp=%0b/%h/%0d", cyc, mc_wr, mc_addr, mc_len, m_wr, m_addr, m_len); end
                if (m_owner == 2 && m_wr) begin
                    checks++; if (mc_wdata !== m_wdata) begin failures++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", cyc, mc_wdata, m_wdata); end
                end
            end
            // requesters drop on their visible done pulse, otherwise may raise a new request
            if (m_ifd && rdy) if_req = 1'b0;
            else if (!if_req && ($urandom % 4 == 0)) begin if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFC0; end
            if (m_lsbd && rdy) lsb_req = 1'b0;
            else if (!lsb_req && ($urandom % 3 == 0)) begin
                lsb_req = 1'b1; lsb_wr = 1'($urandom); lsb_addr = $urandom;
                lsb_len = 3'(1 << $urandom_range(0, 2)); lsb_wdata = $urandom;
            end
            rollback = ($urandom % 12 == 0);
            rdy = ($urandom % 6 != 0);
            if (m_phase != 1) begin
                done_issued = 0; lat = $urandom_range(0, 3); mc_done = 1'b0;
            end else if (!done_issued && rdy) begin
                if (lat == 0) begin mc_done = 1'b1; done_issued = 1; end
                else begin lat--; mc_done = 1'b0; end
            end else begin
                mc_done = 1'b0;
            end
            if (rdy) begin
                served = (m_phase == 1) && (m_owner == 1) && !m_cancel;
                gi = 0; ifd_n = 0; lsbd_n = 0;
                if (m_phase == 0) begin
                    if (!rollback) begin
                        if (lsb_req && (!if_req || m_wait < LIM)) begin
                            m_phase = 1; m_owner = 2; m_cancel = 0; m_wr = lsb_wr;
                            m_addr = lsb_addr; m_len = {4'd0, lsb_len}; m_wdata = lsb_wdata;
                        end else if (if_req) begin
                            m_phase = 1; m_owner = 1; m_cancel = 0; m_wr = 0;
                            m_addr = if_addr; m_len = 7'(IFL); gi = 1;
                        end
                    end
                end else if (m_phase == 1) begin
                    if (rollback && (m_owner == 1 || !m_wr)) m_cancel = 1;
                    if (mc_done) begin
                        m_phase = 2;
                        if (!m_cancel) begin
                            if (m_owner == 1) ifd_n = 1;
                            else lsbd_n = 1;
                        end
                    end
                end else begin
                    m_phase = 0;
                end
                if (!if_req || gi) m_wait = 0;
                else if (!served && m_wait < 255) m_wait++;
                m_ifd = ifd_n; m_lsbd = lsbd_n;
            end
            step();
        end
        if_req = 1'b0; lsb_req = 1'b0; rollback = 1'b0; mc_done = 1'b0; rdy = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_lsb_priority();
        test_if_alone();
        test_starvation();
        test_rollback_if();
        test_rollback_store();
        test_rdy_hold();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
